sysid_check_ctrl: RTL and testbench
===================================

# sysid_check_ctrl

Boot-time sequencer and access arbiter for the system-ID slave. After reset it reads the ID word (address 0) and the build timestamp (address 1), compares both against expected parameters, and publishes pass/fail status to the board-status logic. Once the check completes it shares the slave with a host Avalon-MM master. Host reads stall while a check sequence is running.

## Interface
- EXPECTED_ID, default 0: expected 32-bit word at slave address 0.
- EXPECTED_TS, default 1488914704: expected 32-bit timestamp at slave address 1.
- SETTLE_CYCLES, default 4: idle cycles after reset before the first read. 0 is legal. Counter width is max(1, clog2(SETTLE_CYCLES+1)).
- clock  in  1  single system clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- sys_address  out  1  registered address to the system-ID slave.
- sys_readdata  in  32  combinational read data from the slave, valid in the same cycle as sys_address.
- host_read  in  1  host read request.
- host_address  in  1  host word address.
- host_waitrequest  out  1  stall; combinational from state and host_read.
- host_readdata  out  32  host read data; valid only in the cycle host_waitrequest=0 with host_read=1.
- recheck  in  1  single-cycle pulse that restarts the check.
- busy  out  1  check sequence in progress.
- done  out  1  check complete; results valid.
- id_ok, ts_ok  out  1 each  compare results.
- id_value, ts_value  out  32 each  captured words.

## Operation
- States: SETTLE, RD_ID, RD_TS, CMP, DONE, HOST.
- SETTLE: the counter runs from 0 to SETTLE_CYCLES-1, then the FSM moves to RD_ID. With SETTLE_CYCLES=0 the FSM goes directly to RD_ID.
- RD_ID: sys_address=0. id_value captures sys_readdata at the end of the cycle. Next state is RD_TS.
- RD_TS: sys_address=1. ts_value captures sys_readdata. Next state is CMP.
- CMP: id_ok <= (id_value==EXPECTED_ID); ts_ok <= (ts_value==EXPECTED_TS). Next state is DONE.
- busy=1 in SETTLE, RD_ID, RD_TS and CMP; 0 otherwise. done=1 only in DONE and HOST.
- DONE with recheck=1: next state is RD_ID; SETTLE is not repeated. id_ok, ts_ok and done clear on entry.
- DONE with host_read=1 and recheck=0:
  - host_waitrequest=1 this cycle.
  - sys_address <= host_address.
  - Next state is HOST.
- HOST:
  - host_waitrequest=0.
  - host_readdata=sys_readdata.
  - Next state is DONE.
  - recheck arriving in HOST is honoured on the following DONE cycle.
- recheck in SETTLE, RD_ID, RD_TS or CMP is ignored.
- host_read while busy: host_waitrequest=1 until the sequence reaches DONE, then normal arbitration applies.
- host_read and recheck together in DONE: recheck wins and the host stalls.
- host_readdata=0 whenever the FSM is not in HOST.
- Reset, including mid-sequence:
  - State goes to SETTLE and the counter to 0.
  - sys_address, id_value, ts_value, id_ok, ts_ok, done and host_readdata go to 0.
  - busy=1 and host_waitrequest=1.

## Timing
- Cycle 0 is the first edge with reset_n=1. Let S=SETTLE_CYCLES.
- RD_ID occupies cycle S, RD_TS cycle S+1, CMP cycle S+2.
- done=1 and busy=0 from cycle S+3. For S=4, done rises at cycle 7.
- Recheck accepted in cycle R: RD_ID at R+1, done=0 from R+1, done=1 again at R+4.
- Host read from DONE takes 2 cycles: one stall cycle, then one data cycle. Back-to-back host reads give one word every 2 cycles.
- Host reads issued during a check stall until DONE plus 1 cycle.

## Test plan
- Reset release, slave returns 0 and 1488914704, S=4 -> done=1 at cycle 7; id_ok=1, ts_ok=1, id_value=0, ts_value=1488914704.
- Slave timestamp returns 0x12345678 -> ts_ok=0, id_ok=1, ts_value=0x12345678, done=1 at cycle 7.
- host_read addr 1 in DONE -> waitrequest 1 then 0; host_readdata=1488914704 in the second cycle; done stays 1.
- host_read held from cycle 0 -> waitrequest=1 through cycle 7; data returned at cycle 8.
- recheck and host_read together in DONE -> RD_ID the next cycle, host stalls, done returns after 3 cycles, then host completes.
- reset_n low for 1 cycle during RD_TS -> all outputs at reset values; sequence restarts with full SETTLE; recheck pulses during busy have no effect.

Source files
------------

// File: rtl/sysid_check_ctrl.sv
// Boot-time system-ID check sequencer: reads ID and timestamp words, compares them
// against expected values, then arbitrates the slave for a host Avalon-MM master.
module sysid_check_ctrl #(
   parameter logic [31:0] EXPECTED_ID   = 32'd0,
   parameter logic [31:0] EXPECTED_TS   = 32'd1488914704,
   parameter int          SETTLE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        sys_address,
   input  logic [31:0] sys_readdata,
   input  logic        host_read,
   input  logic        host_address,
   output logic        host_waitrequest,
   output logic [31:0] host_readdata,
   input  logic        recheck,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LAST = (SETTLE_CYCLES == 0) ? '0 : CW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {SETTLE, RD_ID, RD_TS, CMP, DONE, HOST} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic          r_addr;
   logic [31:0]   r_id;
   logic [31:0]   r_ts;
   logic          r_id_ok;
   logic          r_ts_ok;
   logic          r_pend;     // recheck seen during HOST, acted on in the next DONE
   logic          w_restart;

   always_comb begin
      w_next    = r_state;
      w_restart = 1'b0;
      case (r_state)
         SETTLE: if (SETTLE_CYCLES == 0 || r_cnt == LAST) w_next = RD_ID;
         RD_ID:  w_next = RD_TS;
         RD_TS:  w_next = CMP;
         CMP:    w_next = DONE;
         DONE: begin
            if (recheck || r_pend) begin
               w_next    = RD_ID;
               w_restart = 1'b1;
            end else if (host_read) begin
               w_next = HOST;
            end
         end
         HOST:    w_next = DONE;
         default: w_next = SETTLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= SETTLE;
         r_cnt   <= '0;
         r_addr  <= 1'b0;
         r_id    <= '0;
         r_ts    <= '0;
         r_id_ok <= 1'b0;
         r_ts_ok <= 1'b0;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == SETTLE) r_cnt <= r_cnt + 1'b1;
         case (w_next)
            RD_ID:   r_addr <= 1'b0;
            RD_TS:   r_addr <= 1'b1;
            HOST:    r_addr <= host_address;
            default: r_addr <= r_addr;
         endcase
         if (r_state == RD_ID) r_id <= sys_readdata;
         if (r_state == RD_TS) r_ts <= sys_readdata;
         if (r_state == CMP) begin
            r_id_ok <= (r_id == EXPECTED_ID);
            r_ts_ok <= (r_ts == EXPECTED_TS);
         end
         if (w_restart) begin
            r_id_ok <= 1'b0;
            r_ts_ok <= 1'b0;
            r_pend  <= 1'b0;
         end else if (r_state == HOST && recheck) begin
            r_pend <= 1'b1;
         end
      end
   end

   assign sys_address      = r_addr;
   assign busy             = (r_state == SETTLE) || (r_state == RD_ID) ||
                             (r_state == RD_TS)  || (r_state == CMP);
   assign done             = (r_state == DONE) || (r_state == HOST);
   assign host_waitrequest = (r_state != HOST);
   assign host_readdata    = (r_state == HOST) ? sys_readdata : 32'd0;
   assign id_ok            = r_id_ok;
   assign ts_ok            = r_ts_ok;
   assign id_value         = r_id;
   assign ts_value         = r_ts;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl: boot timing, compare results, host arbitration,
// recheck and mid-sequence reset, with host read data checked through a scoreboard queue.
module tb_sysid_check_ctrl;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        sys_address;
   logic [31:0] sys_readdata;
   logic        host_read;
   logic        host_address;
   logic        host_waitrequest;
   logic [31:0] host_readdata;
   logic        recheck;
   logic        busy;
   logic        done;
   logic        id_ok;
   logic        ts_ok;
   logic [31:0] id_value;
   logic [31:0] ts_value;

   logic [31:0] id_word;
   logic [31:0] ts_word;
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clock = ~clock;

   // slave: combinational read of the two-word ID block
   assign sys_readdata = sys_address ? ts_word : id_word;

   sysid_check_ctrl dut (
      .clock(clock), .reset_n(reset_n), .sys_address(sys_address),
      .sys_readdata(sys_readdata), .host_read(host_read), .host_address(host_address),
      .host_waitrequest(host_waitrequest), .host_readdata(host_readdata),
      .recheck(recheck), .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
      .id_value(id_value), .ts_value(ts_value)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic chk_reset_state();
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wait", 32'(host_waitrequest), 32'd1);
      chk("rst_addr", 32'(sys_address), 32'd0);
      chk("rst_idv", id_value, 32'd0);
      chk("rst_tsv", ts_value, 32'd0);
      chk("rst_ok", {30'd0, id_ok, ts_ok}, 32'd0);
      chk("rst_hrd", host_readdata, 32'd0);
   endtask

   // Host read issued in the current cycle; optional recheck pulse alongside it.
   task automatic host_rd(input logic a, input int exp_stall, input bit rc);
      int stalls = 0;
      host_read    = 1'b1;
      host_address = a;
      recheck      = rc;
      exp_q.push_back(a ? ts_word : id_word);
      #1;
      while (host_waitrequest && stalls < 50) begin
         stalls++;
         cyc();
         recheck = 1'b0;
      end
      chk("stall_cycles", 32'(stalls), 32'(exp_stall));
      chk("host_data", host_readdata, exp_q.pop_front());
      chk("done_in_host", 32'(done), 32'd1);
      host_read = 1'b0;
      cyc();
   endtask

   initial begin
      reset_n = 1'b0; host_read = 1'b0; host_address = 1'b0; recheck = 1'b0;
      id_word = 32'd0; ts_word = 32'd1488914704;
      @(negedge clock);
      cyc(); cyc();
      chk_reset_state();

      // boot with matching words
      reset_n = 1'b1;
      repeat (4) cyc();
      chk("c4_rd_id_addr", 32'(sys_address), 32'd0);
      chk("c4_busy", 32'(busy), 32'd1);
      cyc();
      chk("c5_rd_ts_addr", 32'(sys_address), 32'd1);
      cyc();
      chk("c6_done", 32'(done), 32'd0);
      cyc();
      chk("c7_done", 32'(done), 32'd1);
      chk("c7_busy", 32'(busy), 32'd0);
      chk("c7_oks", {30'd0, id_ok, ts_ok}, 32'd3);
      chk("c7_idv", id_value, 32'd0);
      chk("c7_tsv", ts_value, 32'd1488914704);

      // host reads from DONE, back to back
      host_rd(1'b1, 1, 1'b0);
      host_rd(1'b0, 1, 1'b0);
      host_rd(1'b0, 1, 1'b0);

      // bad timestamp, host read held from cycle 0
      ts_word = 32'h12345678;
      reset_n = 1'b0;
      cyc(); cyc();
      reset_n = 1'b1;
      host_rd(1'b1, 8, 1'b0);
      chk("bad_ts_ok", 32'(ts_ok), 32'd0);
      chk("bad_id_ok", 32'(id_ok), 32'd1);
      chk("bad_tsv", ts_value, 32'h12345678);

      // recheck and host read together: recheck wins, host waits for the new result
      id_word = 32'h5;
      host_rd(1'b0, 5, 1'b1);
      chk("rc_idv", id_value, 32'h5);
      chk("rc_id_ok", 32'(id_ok), 32'd0);

      // recheck alone, then reset during RD_TS
      id_word = 32'd0; ts_word = 32'd1488914704;
      recheck = 1'b1;
      cyc();
      recheck = 1'b0;
      chk("rc1_done", 32'(done), 32'd0);
      chk("rc1_busy", 32'(busy), 32'd1);
      chk("rc1_addr", 32'(sys_address), 32'd0);
      chk("rc1_oks", {30'd0, id_ok, ts_ok}, 32'd0);
      cyc();
      chk("rc2_addr", 32'(sys_address), 32'd1);
      reset_n = 1'b0;
      cyc();
      chk_reset_state();
      reset_n = 1'b1;
      cyc();
      recheck = 1'b1;
      cyc();
      recheck = 1'b0;
      cyc(); cyc();
      chk("rs4_addr", 32'(sys_address), 32'd0);
      chk("rs4_busy", 32'(busy), 32'd1);
      cyc(); cyc();
      chk("rs6_done", 32'(done), 32'd0);
      cyc();
      chk("rs7_done", 32'(done), 32'd1);
      chk("rs7_oks", {30'd0, id_ok, ts_ok}, 32'd3);
      cyc(); cyc();
      chk("rs9_done", 32'(done), 32'd1);
      chk("rs9_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
